// File: rtl/tim_seq.sv
// Segment-table timer sequencer: programs an external timer entry by entry and counts its
// compare pulses. Define TIM_SEQ_IRQ_EN to add the irq output and the STATUS b2 pending flag.
module tim_seq #(
  parameter int unsigned N_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Write,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic [3:0]  TWrite,
  output logic [31:0] TAddr,
  output logic [31:0] TWData,
  input  logic        tim_in
`ifdef TIM_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  typedef enum logic [2:0] {StIdle, StWrPsc, StWrMode, StWrPer, StRun} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, sel_q;
  logic [IW:0]   num_q;
  logic [7:0]    rep_cnt_q, rep_lim_q, rep_tgt;
  logic          tim_q, done_q, loop_q, irq_pend;
  logic [2:0]    rsel;
  logic          wr_ctrl, start, stop, rise, running, seg_hit, last, start_go, set_done;
  logic [3:0]    idx4;

  logic [31:0] psc_mem [N_ENTRIES];
  logic [15:0] per_mem [N_ENTRIES];
  logic [7:0]  rep_mem [N_ENTRIES];

  logic unused_addr;
  assign unused_addr = ^{Addr[31:5], Addr[1:0]};

  assign rsel     = Addr[4:2];
  assign wr_ctrl  = Write[0] && (rsel == 3'd0);
  // Stop wins over a simultaneous start.
  assign stop     = wr_ctrl && WData[1];
  assign start    = wr_ctrl && WData[0] && !WData[1];
  assign rise     = tim_in && !tim_q;
  assign running  = (state_q == StRun);
  assign rep_tgt  = (rep_lim_q == 8'd0) ? 8'd1 : rep_lim_q;
  assign seg_hit  = running && rise && ((rep_cnt_q + 8'd1) == rep_tgt);
  assign last     = !(((IW+1)'(idx_q) + (IW+1)'(1)) < num_q);
  assign start_go = (state_q == StIdle) && start;
  assign set_done = (start_go && (num_q == '0)) || (seg_hit && last && !loop_q && !stop);
  assign idx4     = 4'(idx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_q <= 1'b0;
      sel_q  <= '0;
      num_q  <= '0;
    end else begin
      if (wr_ctrl) loop_q <= WData[2];
      if (Write[0] && (rsel == 3'd2)) sel_q <= WData[IW-1:0];
      if (Write[0] && (rsel == 3'd5)) num_q <= WData[IW:0];
    end
  end

  // Table contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (rsel == 3'd3) begin
      for (int b = 0; b < 4; b++) begin
        if (Write[b]) psc_mem[sel_q][8*b +: 8] <= WData[8*b +: 8];
      end
    end
    if (rsel == 3'd4) begin
      if (Write[0]) per_mem[sel_q][7:0]  <= WData[7:0];
      if (Write[1]) per_mem[sel_q][15:8] <= WData[15:8];
      if (Write[2]) rep_mem[sel_q]       <= WData[23:16];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (start && (num_q != '0)) state_d = StWrPsc;
        StWrPsc:  state_d = StWrMode;
        StWrMode: state_d = StWrPer;
        StWrPer:  state_d = StRun;
        StRun:    if (seg_hit) state_d = (last && !loop_q) ? StIdle : StWrPsc;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    TWrite = 4'h0;
    TAddr  = 32'h0;
    TWData = 32'h0;
    unique case (state_q)
      StWrPsc: begin
        TWrite = 4'hF;
        TWData = psc_mem[idx_q];
      end
      StWrMode: begin
        TWrite = 4'hF;
        TAddr  = 32'h4;
      end
      StWrPer: begin
        TWrite = 4'hF;
        TAddr  = 32'h8;
        TWData = {16'd0, per_mem[idx_q]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      rep_cnt_q <= '0;
      rep_lim_q <= '0;
      tim_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tim_q <= tim_in;
      if (stop) begin
        rep_cnt_q <= '0;
      end else if (start_go) begin
        rep_cnt_q <= '0;
        if (num_q != '0) begin
          idx_q  <= '0;
          done_q <= 1'b0;
        end
      end else if (seg_hit) begin
        rep_cnt_q <= '0;
        if (!last)       idx_q <= idx_q + IW'(1);
        else if (loop_q) idx_q <= '0;
      end else if (running && rise) begin
        rep_cnt_q <= rep_cnt_q + 8'd1;
      end
      if (set_done) done_q <= 1'b1;
      // Repeat count is captured at load so table edits apply to the next load only.
      if (state_q == StWrPer) rep_lim_q <= rep_mem[idx_q];
    end
  end

`ifdef TIM_SEQ_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_pend <= 1'b0;
    else if (set_done && !done_q) irq_pend <= 1'b1;
    else if (Write[0] && (rsel == 3'd1) && WData[2]) irq_pend <= 1'b0;
  end
  assign irq = irq_pend;
`else
  assign irq_pend = 1'b0;
`endif

  always_comb begin
    RData = 32'h0;
    case (rsel)
      3'd0:    RData = {29'd0, loop_q, 2'b00};
      3'd1:    RData = {20'd0, idx4, 5'd0, irq_pend, done_q, (state_q != StIdle)};
      3'd2:    RData = 32'(sel_q);
      3'd3:    RData = psc_mem[sel_q];
      3'd4:    RData = {8'd0, rep_mem[sel_q], per_mem[sel_q]};
      3'd5:    RData = 32'(num_q);
      default: RData = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_tim_seq.sv
// Bench for tim_seq: register table vectors, then hand sequences with a timer-write scoreboard.
module tb_tim_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Write;
  logic [31:0] Addr, WData, RData;
  logic [3:0]  TWrite;
  logic [31:0] TAddr, TWData;
  logic        tim_in;
`ifdef TIM_SEQ_IRQ_EN
  logic        irq;
`endif

  tim_seq #(.N_ENTRIES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .Write  (Write),
    .Addr   (Addr),
    .WData  (WData),
    .RData  (RData),
    .TWrite (TWrite),
    .TAddr  (TAddr),
    .TWData (TWData),
    .tim_in (tim_in)
`ifdef TIM_SEQ_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tw_cnt = 0;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] a;
    logic [31:0] d;
  } tw_t;
  tw_t exp_q[$];

  typedef struct {
    logic [2:0]  rsel;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];

  logic [31:0] m_psc[4];
  logic [15:0] m_per[4];

  // Timer-port scoreboard: every write cycle must match the next expected entry.
  always @(negedge clk) begin : mon
    tw_t e;
    if (!rst && TWrite != 4'h0) begin
      tw_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected timer write: got we=%h a=%h d=%h expected none",
                 TWrite, TAddr, TWData);
      end else begin
        e = exp_q.pop_front();
        if ({TWrite, TAddr, TWData} !== {e.we, e.a, e.d}) begin
          errors++;
          $display("FAIL timer write: got we=%h a=%h d=%h expected we=%h a=%h d=%h",
                   TWrite, TAddr, TWData, e.we, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] r, input logic [31:0] d, input logic [3:0] be);
    Addr  = {27'd0, r, 2'b00};
    WData = d;
    Write = be;
    step(1);
    Write = 4'h0;
  endtask

  task automatic rd(input logic [2:0] r, output logic [31:0] d);
    Addr = {27'd0, r, 2'b00};
    #1;
    d = RData;
  endtask

  // STATUS compare with the irq_pend bit masked; irq is checked on its own.
  task automatic chk_status(input string name, input logic [31:0] exp);
    logic [31:0] v;
    rd(3'd1, v);
    chk(name, v & ~32'h4, exp);
  endtask

  task automatic prog(input int i, input logic [31:0] psc, input logic [15:0] per,
                      input logic [7:0] rep);
    wr(3'd2, i, 4'hF);
    wr(3'd3, psc, 4'hF);
    wr(3'd4, {8'd0, rep, per}, 4'hF);
    m_psc[i] = psc;
    m_per[i] = per;
  endtask

  task automatic push_entry(input int i);
    exp_q.push_back('{we: 4'hF, a: 32'h0, d: m_psc[i]});
    exp_q.push_back('{we: 4'hF, a: 32'h4, d: 32'h0});
    exp_q.push_back('{we: 4'hF, a: 32'h8, d: {16'd0, m_per[i]}});
  endtask

  task automatic pulse();
    tim_in = 1'b1;
    step(2);
    tim_in = 1'b0;
    step(2);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] v;
    int n0;

    vecs[0]  = '{3'd2, 32'hFFFF_FF01, 4'h1, 32'h0000_0001};
    vecs[1]  = '{3'd3, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
    vecs[2]  = '{3'd3, 32'h1122_3344, 4'h5, 32'hDE22_BE44};
    vecs[3]  = '{3'd4, 32'hAABB_CCDD, 4'hF, 32'h00BB_CCDD};
    vecs[4]  = '{3'd4, 32'h0077_0000, 4'h4, 32'h0077_CCDD};
    vecs[5]  = '{3'd2, 32'h0000_0003, 4'h0, 32'h0000_0001};
    vecs[6]  = '{3'd2, 32'h0000_0007, 4'h1, 32'h0000_0003};
    vecs[7]  = '{3'd5, 32'h0000_0203, 4'h1, 32'h0000_0003};
    vecs[8]  = '{3'd0, 32'h0000_0004, 4'h1, 32'h0000_0004};
    vecs[9]  = '{3'd0, 32'h0000_0000, 4'h2, 32'h0000_0004};
    vecs[10] = '{3'd0, 32'h0000_0000, 4'h1, 32'h0000_0000};
    vecs[11] = '{3'd6, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[12] = '{3'd7, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[13] = '{3'd1, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[14] = '{3'd5, 32'h0000_0000, 4'h1, 32'h0000_0000};

    rst = 1'b1; Write = 4'h0; Addr = 32'h0; WData = 32'h0; tim_in = 1'b0;
    #2;
    chk("reset TWrite", 32'(TWrite), 32'h0);
    chk("reset TAddr", TAddr, 32'h0);
    chk("reset TWData", TWData, 32'h0);
    rd(3'd1, v); chk("reset STATUS", v, 32'h0);
    rd(3'd0, v); chk("reset CTRL", v, 32'h0);
    rd(3'd2, v); chk("reset SEL", v, 32'h0);
    rd(3'd5, v); chk("reset NUM", v, 32'h0);
    step(1);
    rst = 1'b0;
    step(1);

    for (int i = 0; i < 15; i++) begin
      wr(vecs[i].rsel, vecs[i].wdata, vecs[i].be);
      rd(vecs[i].rsel, v);
      chk($sformatf("regvec %0d", i), v, vecs[i].exp);
    end

    // Single entry, repeat 2.
    prog(0, 32'd3, 16'd5, 8'd2);
    wr(3'd5, 32'd1, 4'h1);
    push_entry(0);
    wr(3'd0, 32'h1, 4'h1);
    step(3);
    chk("seq1 writes consumed", exp_q.size(), 0);
    chk_status("seq1 running", 32'h001);
    pulse();
    chk_status("seq1 after one edge", 32'h001);
    tim_in = 1'b1;
    step(1);
    chk_status("seq1 done", 32'h002);
    tim_in = 1'b0;
    step(1);
`ifdef TIM_SEQ_IRQ_EN
    chk("irq raised", 32'(irq), 32'h1);
    wr(3'd1, 32'h4, 4'h1);
    chk("irq cleared", 32'(irq), 32'h0);
`else
    rd(3'd1, v); chk("STATUS b2 zero", 32'(v[2]), 32'h0);
`endif

    // Three entries, repeats 1/2/1, no loop.
    prog(0, 32'd10, 16'd100, 8'd1);
    prog(1, 32'd11, 16'd101, 8'd2);
    prog(2, 32'd12, 16'd102, 8'd1);
    wr(3'd5, 32'd3, 4'h1);
    push_entry(0);
    wr(3'd0, 32'h1, 4'h1);
    step(3);
    chk("seq2 entry0", exp_q.size(), 0);
    chk_status("seq2 idx0", 32'h001);
    push_entry(1);
    pulse();
    chk("seq2 entry1", exp_q.size(), 0);
    chk_status("seq2 idx1", 32'h101);
    pulse();
    chk_status("seq2 idx1 half", 32'h101);
    push_entry(2);
    pulse();
    chk("seq2 entry2", exp_q.size(), 0);
    chk_status("seq2 idx2", 32'h201);
    pulse();
    chk_status("seq2 done", 32'h202);

    // Two entries looping, then stop mid-run.
    wr(3'd5, 32'd2, 4'h1);
    push_entry(0);
    wr(3'd0, 32'h5, 4'h1);
    step(3);
    push_entry(1);
    pulse();
    chk("seq3 entry1", exp_q.size(), 0);
    chk_status("seq3 idx1", 32'h101);
    pulse();
    push_entry(0);
    pulse();
    chk("seq3 loop to entry0", exp_q.size(), 0);
    chk_status("seq3 looped", 32'h001);
    wr(3'd0, 32'h2, 4'h1);
    chk_status("seq3 stopped", 32'h000);
    pulse();
    pulse();
    chk_status("seq3 still idle", 32'h000);

    // Start with NUM=0 completes without timer writes.
    n0 = tw_cnt;
    wr(3'd5, 32'd0, 4'h1);
    wr(3'd0, 32'h1, 4'h1);
    chk_status("num0 done", 32'h002);
    step(3);
    chk("num0 no writes", tw_cnt - n0, 0);

    // tim_in high across reprogramming is not an edge; start while busy is ignored.
    prog(0, 32'd7, 16'd9, 8'd1);
    wr(3'd5, 32'd1, 4'h1);
    tim_in = 1'b1;
    step(2);
    push_entry(0);
    wr(3'd0, 32'h1, 4'h1);
    step(5);
    chk_status("held high no count", 32'h001);
    wr(3'd0, 32'h1, 4'h1);
    step(3);
    chk("busy start no writes", exp_q.size(), 0);
    chk_status("busy start ignored", 32'h001);
    tim_in = 1'b0;
    step(1);
    pulse();
    chk_status("held high then edge done", 32'h002);

    // Reset during WR_PER.
    exp_q.push_back('{we: 4'hF, a: 32'h0, d: 32'd7});
    exp_q.push_back('{we: 4'hF, a: 32'h4, d: 32'h0});
    wr(3'd0, 32'h1, 4'h1);
    step(2);
    chk("in WR_PER TAddr", TAddr, 32'h8);
    rst = 1'b1;
    #1;
    chk("async rst TWrite", 32'(TWrite), 32'h0);
    chk("async rst TAddr", TAddr, 32'h0);
    chk("async rst TWData", TWData, 32'h0);
    rd(3'd1, v); chk("async rst STATUS", v, 32'h0);
    rd(3'd5, v); chk("async rst NUM", v, 32'h0);
    step(1);
    rst = 1'b0;
    step(1);
    chk("rst sequence writes", exp_q.size(), 0);

    // Start and stop together resolve as stop.
    wr(3'd5, 32'd1, 4'h1);
    wr(3'd0, 32'h3, 4'h1);
    step(3);
    chk_status("start+stop idle", 32'h000);
    chk("final queue empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
